// File: rtl/lc3b_types.sv
// Shared LC-3b types: machine word and the memory access FSM state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE,
    PTR,
    DATA,
    DONE
  } mem_access_state_t;

endpackage

// File: rtl/mem_byte_align.sv
// Combinational byte-lane steering between the MEM stage and a 16-bit memory.
module mem_byte_align
  import lc3b_types::*;
(
  input  lc3b_word   addr_i,
  input  lc3b_word   wdata_i,
  input  lc3b_word   mem_rdata_i,
  input  logic       byte_i,
  output lc3b_word   mem_address_o,
  output lc3b_word   mem_wdata_o,
  output logic [1:0] byte_enable_o,
  output lc3b_word   rdata_o
);

  // Word accesses are always aligned; byte accesses keep the lane select in bit 0.
  assign mem_address_o = byte_i ? addr_i : {addr_i[15:1], 1'b0};
  assign byte_enable_o = byte_i ? (addr_i[0] ? 2'b10 : 2'b01) : 2'b11;
  assign mem_wdata_o   = byte_i ? {wdata_i[7:0], wdata_i[7:0]} : wdata_i;
  assign rdata_o       = byte_i ? {8'h00, (addr_i[0] ? mem_rdata_i[15:8] : mem_rdata_i[7:0])}
                                : mem_rdata_i;

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: direct and indirect word/byte loads and stores
// against a single-port memory with a one-cycle acknowledge.
module mem_access_unit
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_read,
  input  logic       req_write,
  input  logic       req_byte,
  input  logic       req_indirect,
  input  lc3b_word   req_addr,
  input  lc3b_word   req_wdata,
  output logic       stall,
  output logic       done,
  output lc3b_word   rdata,
  output logic       mem_read,
  output logic       mem_write,
  output lc3b_word   mem_address,
  output lc3b_word   mem_wdata,
  output logic [1:0] mem_byte_enable,
  input  lc3b_word   mem_rdata,
  input  logic       mem_resp
);

  mem_access_state_t state_q, state_d;
  logic     op_write_q, op_write_d;
  logic     byte_q, byte_d;
  logic     indirect_q, indirect_d;
  lc3b_word addr_q, addr_d;
  lc3b_word wdata_q, wdata_d;
  lc3b_word ptr_q, ptr_d;
  lc3b_word rdata_q, rdata_d;

  lc3b_word   align_address;
  lc3b_word   align_wdata;
  lc3b_word   align_rdata;
  logic [1:0] align_be;

  mem_byte_align u_align (
    .addr_i        (indirect_q ? ptr_q : addr_q),
    .wdata_i       (wdata_q),
    .mem_rdata_i   (mem_rdata),
    .byte_i        (byte_q),
    .mem_address_o (align_address),
    .mem_wdata_o   (align_wdata),
    .byte_enable_o (align_be),
    .rdata_o       (align_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_write_q <= 1'b0;
      byte_q     <= 1'b0;
      indirect_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ptr_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      byte_q     <= byte_d;
      indirect_q <= indirect_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      ptr_q      <= ptr_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    op_write_d      = op_write_q;
    byte_d          = byte_q;
    indirect_d      = indirect_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    ptr_d           = ptr_q;
    rdata_d         = rdata_q;
    stall           = 1'b0;
    done            = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = align_address;
    mem_byte_enable = 2'b00;

    case (state_q)
      IDLE: begin
        if (req_read || req_write) begin
          stall      = 1'b1;
          // A simultaneous read and write is a read; indirect forces word size.
          op_write_d = req_write & ~req_read;
          byte_d     = req_byte & ~req_indirect;
          indirect_d = req_indirect;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          state_d    = req_indirect ? PTR : DATA;
        end
      end
      PTR: begin
        stall           = 1'b1;
        mem_read        = 1'b1;
        mem_address     = {addr_q[15:1], 1'b0};
        mem_byte_enable = 2'b11;
        if (mem_resp) begin
          ptr_d   = mem_rdata;
          state_d = DATA;
        end
      end
      DATA: begin
        stall           = 1'b1;
        mem_read        = ~op_write_q;
        mem_write       = op_write_q;
        mem_byte_enable = align_be;
        if (mem_resp) begin
          if (!op_write_q) rdata_d = align_rdata;
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_wdata = align_wdata;
  assign rdata     = rdata_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL use one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-002 SHALL provide the pipeline-side (MEM stage) ports:
- req_read  in  1  load requested (LDR/LDB/LDI).
- req_write  in  1  store requested (STR/STB/STI).
- req_byte  in  1  byte access (LDB/STB).
- req_indirect  in  1  indirect access (LDI/STI).
- req_addr  in  16  effective address.
- req_wdata  in  16  store data.
- stall  out  1  freeze the pipeline.
- done  out  1  one-cycle completion pulse.
- rdata  out  16  load result.
REQ-003 SHALL provide the memory-side ports:
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_address  out  16  memory address.
- mem_wdata  out  16  write data.
- mem_byte_enable  out  2  byte lanes, bit1 = high byte.
- mem_rdata  in  16  read data.
- mem_resp  in  1  one-cycle acknowledge.

Function
REQ-004 SHALL implement a four-state FSM:
- IDLE, PTR, DATA, DONE.
REQ-005 IDLE behaviour:
- On req_read|req_write, SHALL latch op, byte, indirect, addr and wdata.
- SHALL go to PTR if indirect, else DATA.
- stall = 1 combinationally in this same cycle.
REQ-006 PTR behaviour:
- mem_read = 1; mem_address = {addr[15:1],0}; mem_byte_enable = 11.
- On mem_resp, SHALL latch mem_rdata as the pointer and go to DATA.
REQ-007 DATA behaviour:
- Address = pointer if indirect, else latched addr.
- mem_read or mem_write is asserted per the latched op.
- On mem_resp, SHALL go to DONE.
REQ-008 DONE behaviour:
- stall = 0; done = 1 for exactly one cycle.
- SHALL go to IDLE unconditionally.
- A request present in IDLE on the following cycle is treated as a new instruction.
REQ-009 stall SHALL be 1 in PTR and DATA, and in IDLE when a request is present; it SHALL be 0 otherwise.
REQ-010 Word access:
- Address bit0 forced to 0; byte_enable = 11.
- mem_wdata = wdata; rdata = mem_rdata.
REQ-011 Byte access:
- byte_enable = 10 if addr[0] = 1, else 01.
- mem_wdata = {wdata[7:0], wdata[7:0]}.
- rdata = zero-extended selected byte.
REQ-012 req_byte SHALL be ignored when req_indirect = 1 (word semantics).
REQ-013 req_read and req_write both high SHALL be treated as a read.
REQ-014 mem_resp SHALL be ignored in IDLE and DONE.
REQ-015 mem_read/mem_write SHALL stay asserted and address/data stable until mem_resp.
REQ-016 rdata SHALL be written only in DATA on mem_resp of a read, and held until the next read completion.
REQ-017 Latency, with memory responding N ≥ 1 cycles after its strobe rises:
- Direct access: done at cycle N+2 after acceptance.
- Indirect access: done at cycle 2N+3 after acceptance.
REQ-018 mem_read, mem_write, stall and done SHALL be decoded from state only, plus the IDLE request term of stall.

Reset
REQ-019 While rst = 1, asynchronously:
- state = IDLE.
- All latched registers, rdata and the pointer = 0.
- mem_read = mem_write = done = 0; mem_byte_enable = 00.
REQ-020 Reset mid-transaction SHALL abandon it with no done pulse; a mem_resp arriving after reset SHALL be ignored.

Structure
REQ-021 The shared package lc3b_types SHALL hold the lc3b_word type and the FSM enum mem_access_state_t.
REQ-022 Byte-lane steering (REQ-010/011) SHALL sit in one combinational sub-module, mem_byte_align; the FSM and registers SHALL stay in mem_access_unit.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Word read, addr 0x1235, N = 1, mem_rdata 0xBEEF: mem_address 0x1234, be 11, done at cycle 3, rdata 0xBEEF, stall high cycles 0-2.
- STB addr 0x2001, wdata 0x00A5: mem_wdata 0xA5A5, be 10, mem_write until resp, done one cycle.
- LDB addr 0x3000, mem_rdata 0x80F0: rdata 0x00F0.
- LDI addr 0x4000, pointer 0x5002, data 0x1234, N = 2: read 0x4000 then read 0x5002, done at cycle 7, rdata 0x1234.
- rst asserted during DATA of an STI: strobes drop same cycle, state IDLE, no done; a later mem_resp is ignored.
- req_read and req_write both high, then back-to-back requests: a read is performed; second request accepted the cycle after DONE.
